// File: rtl/mem_arb_defs.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the shared memory: D wins ties until I has been passed over STARVE times.
module mem_arb_prio
   import mem_arb_defs::*;
#(
   parameter int STARVE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   input  logic grant,
   output logic win_d
);

   localparam int SW = cnt_width(STARVE + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

   logic [SW-1:0] starve_cnt;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      win_d = 1'b1;
      if (d_req && (starve_cnt < STARVE_MAX))
         win_d = 1'b1;
      else if (i_req)
         win_d = 1'b0;
   end

   // Counts D grants made while I was waiting; an I grant forgives the debt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         starve_cnt <= '0;
      else if (grant) begin
         if (!win_d)
            starve_cnt <= '0;
         else if (i_req && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + SW'(1);
      end
   end

endmodule

// File: rtl/register.sv
// Generic load-enabled datapath register with active-high asynchronous reset.
module register #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter sharing one fixed-latency memory between the I cache and D cache.
module mem_arb
   import mem_arb_defs::*;
#(
   parameter int LAT    = 4,
   parameter int STARVE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_done,
   output logic [15:0] i_rdata,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy,
   output logic        err
);

   localparam int CW = cnt_width(LAT);

   state_t        state, state_nxt;
   owner_t        owner;
   logic [CW-1:0] lat_cnt;
   logic          win_d, grant, own_req, cap;
   logic          mem_en_nxt, busy_nxt, i_done_nxt, d_done_nxt;
   logic [15:0]   addr_sel, wdata_sel;

   assign grant     = (state == IDLE) && (i_req || d_req);
   assign own_req   = (owner == OWN_D) ? d_req : i_req;
   assign cap       = (state == WAIT) && (lat_cnt == '0);
   assign addr_sel  = win_d ? d_addr : i_addr;
   assign wdata_sel = win_d ? d_wdata : '0;

   mem_arb_prio #(.STARVE(STARVE)) u_prio (
      .clk   (clk),
      .rst   (rst),
      .i_req (i_req),
      .d_req (d_req),
      .grant (grant),
      .win_d (win_d)
   );

   // State register; the strobes are registered here so outputs never see inputs combinationally.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         mem_en <= 1'b0;
         busy   <= 1'b0;
         i_done <= 1'b0;
         d_done <= 1'b0;
      end else begin
         state  <= state_nxt;
         mem_en <= mem_en_nxt;
         busy   <= busy_nxt;
         i_done <= i_done_nxt;
         d_done <= d_done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_req || d_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (lat_cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_en_nxt = (state_nxt == ISSUE);
      busy_nxt   = (state_nxt != IDLE);
      i_done_nxt = (state_nxt == DONE) && (owner == OWN_I);
      d_done_nxt = (state_nxt == DONE) && (owner == OWN_D);
   end

   // Transaction control: owner, write qualifier, latency count and sticky protocol error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner   <= OWN_D;
         mem_wr  <= 1'b0;
         lat_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (grant) begin
            owner  <= win_d ? OWN_D : OWN_I;
            mem_wr <= win_d & d_wr;
         end
         if (state == ISSUE)
            lat_cnt <= CW'(LAT - 1);
         else if (state == WAIT)
            lat_cnt <= lat_cnt - CW'(1);
         if (((state == ISSUE) || (state == WAIT)) && !own_req)
            err <= 1'b1;
      end
   end

   register #(.W(16)) u_mem_addr (
      .clk (clk), .rst (~rst), .en (grant), .d (addr_sel), .q (mem_addr)
   );

   register #(.W(16)) u_mem_wdata (
      .clk (clk), .rst (~rst), .en (grant), .d (wdata_sel), .q (mem_wdata)
   );

   register #(.W(16)) u_i_rdata (
      .clk (clk), .rst (~rst), .en (cap && (owner == OWN_I)), .d (mem_rdata), .q (i_rdata)
   );

   // D writes complete without touching d_rdata.
   register #(.W(16)) u_d_rdata (
      .clk (clk), .rst (~rst), .en (cap && (owner == OWN_D) && !mem_wr), .d (mem_rdata), .q (d_rdata)
   );

endmodule

// File: tb/tb_mem_arb.sv
// Directed scenarios plus randomized two-requester traffic against a transaction-level model of mem_arb.
module tb_mem_arb;

   localparam int LAT    = 4;
   localparam int STARVE = 4;
   localparam int P      = LAT + 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic        i_done, d_done, mem_en, mem_wr, busy, err;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   always #5 clk = ~clk;

   mem_arb #(.LAT(LAT), .STARVE(STARVE)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_done    (i_done),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          pend_at = -1;
   logic [15:0] pend_addr = '0;
   logic [15:0] mem_model [int];
   logic [15:0] i_rd_exp = '0, d_rd_exp = '0;

   function automatic logic [15:0] mem_read(input logic [15:0] a);
      if (mem_model.exists(int'(a)))
         return mem_model[int'(a)];
      return 16'(a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: sample at the falling edge and play the memory side.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (!rst)
         pend_at = -1;
      else if (mem_en === 1'b1) begin
         pend_at   = cyc + LAT;
         pend_addr = mem_addr;
         if (mem_wr === 1'b1)
            mem_model[int'(mem_addr)] = mem_wdata;
      end
      if (cyc == pend_at)
         mem_rdata = mem_read(pend_addr);
      else
         mem_rdata = 16'($urandom);
   endtask

   // A lone request raised in cycle 0; checks every cycle through the following IDLE.
   task automatic run_one(input string tag, input bit is_d, input bit wr,
                          input logic [15:0] addr, input logic [15:0] wdata);
      logic [15:0] exp;
      exp = mem_read(addr);
      if (is_d) begin
         d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      for (int k = 1; k <= LAT + 3; k++) begin
         tick();
         check({tag, ".mem_en"}, mem_en, k == 1);
         check({tag, ".busy"}, busy, (k >= 1) && (k <= LAT + 2));
         check({tag, ".i_done"}, i_done, !is_d && (k == LAT + 2));
         check({tag, ".d_done"}, d_done, is_d && (k == LAT + 2));
         if (k == 1) begin
            check({tag, ".mem_addr"}, mem_addr, addr);
            check({tag, ".mem_wr"}, mem_wr, is_d && wr);
            if (is_d && wr)
               check({tag, ".mem_wdata"}, mem_wdata, wdata);
         end
         if (k == LAT + 2) begin
            if (!is_d) i_rd_exp = exp;
            else if (!wr) d_rd_exp = exp;
            check({tag, ".i_rdata"}, i_rdata, i_rd_exp);
            check({tag, ".d_rdata"}, d_rdata, d_rd_exp);
            if (is_d) d_req = 1'b0; else i_req = 1'b0;
         end
      end
   endtask

   initial begin
      int          idle_from, starve, t_issue;
      bit          prev_i, prev_d, act, t_d, t_wr, exp_en, win_d, done_now, stim_on;
      logic [15:0] t_addr, t_exp, e_addr;

      repeat (2) tick();
      check("rst.busy", busy, 0);
      check("rst.mem_en", mem_en, 0);
      check("rst.mem_wr", mem_wr, 0);
      check("rst.mem_addr", mem_addr, 0);
      check("rst.mem_wdata", mem_wdata, 0);
      check("rst.i_rdata", i_rdata, 0);
      check("rst.d_rdata", d_rdata, 0);
      check("rst.err", err, 0);
      check("rst.done", {i_done, d_done}, 0);
      rst = 1'b1;
      tick();
      check("idle.busy", busy, 0);

      mem_model[int'(16'h0040)] = 16'hBEEF;
      run_one("i_read", 1'b0, 1'b0, 16'h0040, 16'h0000);
      check("i_read.beef", i_rdata, 16'hBEEF);
      run_one("d_read", 1'b1, 1'b0, 16'h2000, 16'h0000);
      run_one("d_write", 1'b1, 1'b1, 16'h1000, 16'h1234);
      check("d_write.keep", d_rdata, mem_read(16'h2000));

      // Simultaneous requests: D first, then I one IDLE later.
      i_req = 1'b1; i_addr = 16'h0300;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
      for (int k = 1; k <= 2 * LAT + 6; k++) begin
         tick();
         check("tie.mem_en", mem_en, (k == 1) || (k == LAT + 4));
         check("tie.d_done", d_done, k == LAT + 2);
         check("tie.i_done", i_done, k == 2 * LAT + 5);
         if (k == 1) check("tie.d_addr", mem_addr, 16'h0400);
         if (k == LAT + 4) begin
            check("tie.i_addr", mem_addr, 16'h0300);
            check("tie.i_wr", mem_wr, 0);
         end
         if (k == LAT + 2) begin
            d_rd_exp = mem_read(16'h0400);
            check("tie.d_rdata", d_rdata, d_rd_exp);
            d_req = 1'b0;
         end
         if (k == 2 * LAT + 5) begin
            i_rd_exp = mem_read(16'h0300);
            check("tie.i_rdata", i_rdata, i_rd_exp);
            i_req = 1'b0;
         end
      end

      // Starvation: four D grants, then I forced through, then D again.
      i_req = 1'b1; i_addr = 16'h6000;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h5000;
      for (int k = 1; k <= 6 * P; k++) begin
         int j;
         tick();
         j = (k - 1) / P;
         check("starve.mem_en", mem_en, ((k - 1) % P == 0) && (j <= 5));
         if (((k - 1) % P == 0) && (j <= 5)) begin
            e_addr = (j == 4) ? 16'h6000 : 16'h5000 + 16'((j < 4) ? j : 4);
            check("starve.order", mem_addr, e_addr);
         end
         j = (k - LAT - 2) / P;
         done_now = (k >= LAT + 2) && ((k - LAT - 2) % P == 0) && (j <= 5);
         check("starve.i_done", i_done, done_now && (j == 4));
         check("starve.d_done", d_done, done_now && (j != 4));
         if (done_now && (j == 4)) begin
            i_rd_exp = mem_read(16'h6000);
            check("starve.i_rdata", i_rdata, i_rd_exp);
            i_req = 1'b0;
         end else if (done_now) begin
            d_rd_exp = mem_read(d_addr);
            check("starve.d_rdata", d_rdata, d_rd_exp);
            if (j < 5) d_addr = d_addr + 16'd1;
            else d_req = 1'b0;
         end
      end

      // Reset two cycles after issue abandons the access.
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h7000;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("mid_rst.mem_en", mem_en, k == 1);
         check("mid_rst.d_done", d_done, 0);
      end
      rst = 1'b0;
      #1;
      check("mid_rst.busy", busy, 0);
      check("mid_rst.mem_en_now", mem_en, 0);
      check("mid_rst.rdata", {i_rdata, d_rdata}, 0);
      i_rd_exp = '0;
      d_rd_exp = '0;
      tick();
      check("mid_rst.hold_busy", busy, 0);
      check("mid_rst.no_done", {i_done, d_done}, 0);
      rst = 1'b1;
      run_one("rst_resume", 1'b1, 1'b0, 16'h7000, 16'h0000);

      // Random traffic against a transaction-level model.
      idle_from = cyc; starve = 0; act = 1'b0;
      prev_i = 1'b0; prev_d = 1'b0;
      t_issue = 0; t_d = 1'b0; t_wr = 1'b0; t_addr = '0; t_exp = '0;
      for (int n = 0; n < 1500; n++) begin
         stim_on = (n < 1400);
         tick();
         exp_en = !act && (prev_i || prev_d) && (cyc - 1 >= idle_from);
         check("rnd.mem_en", mem_en, exp_en);
         if (exp_en) begin
            if (prev_d && (starve < STARVE)) win_d = 1'b1;
            else if (prev_i) win_d = 1'b0;
            else win_d = 1'b1;
            t_d    = win_d;
            t_wr   = win_d && d_wr;
            t_addr = win_d ? d_addr : i_addr;
            check("rnd.mem_addr", mem_addr, t_addr);
            check("rnd.mem_wr", mem_wr, t_wr);
            if (t_wr) check("rnd.mem_wdata", mem_wdata, d_wdata);
            t_exp = mem_read(t_addr);
            if (!win_d) starve = 0;
            else if (prev_i && (starve < STARVE)) starve++;
            act = 1'b1;
            t_issue = cyc;
         end
         done_now = act && (cyc == t_issue + LAT + 1);
         check("rnd.i_done", i_done, done_now && !t_d);
         check("rnd.d_done", d_done, done_now && t_d);
         check("rnd.busy", busy, act);
         if (done_now) begin
            if (!t_d) i_rd_exp = t_exp;
            else if (!t_wr) d_rd_exp = t_exp;
         end
         check("rnd.i_rdata", i_rdata, i_rd_exp);
         check("rnd.d_rdata", d_rdata, d_rd_exp);
         check("rnd.err", err, 0);
         if (done_now) begin
            act = 1'b0;
            idle_from = cyc + 1;
            if (t_d) d_req = 1'b0; else i_req = 1'b0;
         end
         if (stim_on && !i_req && ($urandom_range(0, 2) == 0)) begin
            i_req  = 1'b1;
            i_addr = 16'($urandom_range(0, 31));
         end
         if (stim_on && !d_req && ($urandom_range(0, 2) == 0)) begin
            d_req   = 1'b1;
            d_wr    = 1'($urandom_range(0, 1));
            d_addr  = 16'($urandom_range(0, 31));
            d_wdata = 16'($urandom);
         end
         prev_i = i_req;
         prev_d = d_req;
      end
      check("rnd.drained", busy, 0);

      // Protocol violation: D drops its request during WAIT.
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0900;
      for (int k = 1; k <= LAT + 3; k++) begin
         tick();
         check("viol.err", err, k >= 4);
         check("viol.d_done", d_done, k == LAT + 2);
         check("viol.i_done", i_done, 0);
         if (k == LAT + 2) check("viol.d_rdata", d_rdata, mem_read(16'h0900));
         if (k == 3) d_req = 1'b0;
      end
      rst = 1'b0;
      #1;
      check("viol.err_rst", err, 0);
      tick();
      rst = 1'b1;
      tick();
      check("viol.err_clear", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter for the single shared main memory behind the instruction cache (I side, read-only) and the data cache (D side, read/write) of the pipelined processor. It accepts a miss/writeback request from either cache and issues it to the fixed-latency memory. It returns read data and a one-cycle completion pulse to the owner. D side wins ties, with a starvation guard that bounds how long an I-side fetch can be blocked.

## Interface
Parameters:
- LAT, 4: memory read/write latency in cycles from `mem_en` to valid `mem_rdata`/write complete (≥1)
- STARVE, 4: consecutive D grants allowed while I is pending before I is forced to win (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_req  in  1  I-side request; held high with stable `i_addr` until `i_done`
- i_addr  in  16  I-side word address
- i_done  out  1  one-cycle I completion pulse; `i_rdata` valid this cycle
- i_rdata  out  16  I read data; holds last read value
- d_req  in  1  D-side request; held high with stable `d_wr`/`d_addr`/`d_wdata` until `d_done`
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  16  D-side address
- d_wdata  in  16  D write data
- d_done  out  1  one-cycle D completion pulse
- d_rdata  out  16  D read data; updated only on D read completion
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write qualifier, valid with `mem_en`
- mem_addr  out  16  issued address, held for whole transaction
- mem_wdata  out  16  issued write data, held for whole transaction
- mem_rdata  in  16  memory read data, valid exactly LAT cycles after `mem_en`
- busy  out  1  high in every non-IDLE state
- err  out  1  sticky protocol error

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, select the winner and register `owner`, `mem_addr`, `mem_wr`, and `mem_wdata` (I side forces `mem_wr`=0). Go to ISSUE.
- Winner rule: D if `d_req` and `starve_cnt` < STARVE. Otherwise I if `i_req`. Otherwise D.
- `starve_cnt`: increments (saturating at STARVE) on a D grant while `i_req` is high. Clears on any I grant.
- ISSUE: `mem_en`=1 for exactly this cycle. Load latency counter with LAT-1, then go to WAIT.
- WAIT: decrement the counter. At 0, capture `mem_rdata` into the owner's rdata register (reads only) and go to DONE.
- DONE: assert the owner's done for one cycle. Requests are not sampled in this state. Go to IDLE.
- Write completion: `d_done` pulses and `d_rdata` is unchanged.
- Protocol check: if the owner's req is low in ISSUE or WAIT, set `err`=1. The transaction still completes normally. `err` clears only on reset.
- Requests from the non-owner are ignored until the next IDLE and must be held by the requester.

## Timing
- Reset (rst=0, async) forces:
  - state IDLE
  - all outputs 0: `i_rdata`, `d_rdata`, `mem_*`, `busy`, `err`, done pulses
  - `starve_cnt` 0, owner D
- Reset mid-transaction abandons the memory access. No done pulse is produced.
- Request sampled in IDLE at cycle 0:
  - `mem_en` in cycle 1
  - data captured at the end of cycle 1+LAT
  - done in cycle 2+LAT
  - IDLE again in cycle 3+LAT
- A request held high through DONE is re-arbitrated in cycle 3+LAT. Back-to-back throughput is one transaction per LAT+3 cycles.
- Simultaneous `i_req` and `d_req` in IDLE: D wins unless `starve_cnt`==STARVE.
- `mem_addr`, `mem_wr`, and `mem_wdata` are stable from cycle 1 until leaving DONE.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared defs file `mem_arb_defs`:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3)
  - owner encoding (OWN_I=1'b0, OWN_D=1'b1)
- One sub-module `mem_arb_prio`: the combinational winner-select plus saturating `starve_cnt` register. The FSM, latency counter and data registers stay in `mem_arb`.
- Datapath registers reuse the existing `register` module where width permits. Their reset input is driven by `~rst`, since `register` resets active-high and reset here is active-low.

## Test plan
- Single I read, LAT=4: `i_req`=1, `i_addr`=16'h0040, memory returns 16'hBEEF.
  - Required: `mem_en` at cycle 1, `mem_addr`=16'h0040, `mem_wr`=0.
  - Required: `i_done`=1 at cycle 6, `i_rdata`=16'hBEEF, `d_done` never asserts.
- D write: `d_wr`=1, `d_addr`=16'h1000, `d_wdata`=16'h1234.
  - Required: `mem_en`/`mem_wr`=1 with those values, `d_done` at cycle 6.
  - Required: `d_rdata` unchanged from its prior value.
- Tie: `i_req` and `d_req` rise in the same cycle.
  - Required: D served first with `d_done` at cycle 6; I issued at cycle 8 with `i_done` at cycle 13.
- Starvation, STARVE=4: `i_req` held, `d_req` re-asserted continuously.
  - Required: exactly 4 D transactions, then I is granted, then D resumes.
- Reset mid-WAIT: `rst`=0 for one cycle two cycles after `mem_en`.
  - Required: `busy`=0 and `mem_en`=0 immediately, no done pulse.
  - Required: after release, a pending `d_req` is issued normally.
- Protocol violation: `d_req` dropped during WAIT.
  - Required: `err`=1 the following cycle and it stays 1; `d_done` still pulses at cycle 6.
